// File: rtl/dual_input_debounce.sv
// Two-channel input conditioner: 2-flop synchroniser, stability-count debounce filter,
// registered rise/fall strobes and saturating rejected-glitch counters per channel.
module dual_input_debounce #(
  parameter int unsigned DEB_CYCLES = 10,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned GLT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             A,
  input  logic             B,
  output logic             a_clean,
  output logic             b_clean,
  output logic             a_rise,
  output logic             a_fall,
  output logic             b_rise,
  output logic             b_fall,
  output logic [GLT_W-1:0] a_glitch_cnt,
  output logic [GLT_W-1:0] b_glitch_cnt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  // Channel index 0 is A, index 1 is B.
  logic [1:0]       raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [GLT_W-1:0] glt_q [2];
  logic [GLT_W-1:0] glt_d [2];

  assign raw = {B, A};

  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      glt_d[ch] = glt_q[ch];
      if (s2_q[ch] == state_q[ch]) begin
        // Input fell back to the clean level before the candidate matured.
        if (cnt_q[ch] != '0) begin
          cnt_d[ch] = '0;
          if (glt_q[ch] != '1) begin
            glt_d[ch] = glt_q[ch] + GLT_W'(1);
          end
        end
      end else if (cnt_q[ch] == CntLast) begin
        state_d[ch] = s2_q[ch];
        cnt_d[ch]   = '0;
        rise_d[ch]  = s2_q[ch];
        fall_d[ch]  = ~s2_q[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      glt_q[0] <= '0;
      glt_q[1] <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      glt_q[0] <= glt_d[0];
      glt_q[1] <= glt_d[1];
    end
  end

  assign a_clean      = state_q[0];
  assign b_clean      = state_q[1];
  assign a_rise       = rise_q[0];
  assign a_fall       = fall_q[0];
  assign b_rise       = rise_q[1];
  assign b_fall       = fall_q[1];
  assign a_glitch_cnt = glt_q[0];
  assign b_glitch_cnt = glt_q[1];

endmodule

// File: tb/tb_dual_input_debounce.sv
// Directed bench for dual_input_debounce (DEB_CYCLES=10, GLT_W=8): segment table plus
// hand-written timing sequences for strobe edges, glitch saturation and mid-count reset.
module tb_dual_input_debounce;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
  logic [7:0] a_glitch_cnt, b_glitch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        a;
    logic        b;
    int unsigned ticks;
    logic        ea;
    logic        eb;
    int          ar, af, br, bf;
    int          ga, gb;
  } seg_t;

  seg_t segs[$];

  dual_input_debounce #(
    .DEB_CYCLES(10),
    .CNT_W     (10),
    .GLT_W     (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .A           (a_in),
    .B           (b_in),
    .a_clean     (a_clean),
    .b_clean     (b_clean),
    .a_rise      (a_rise),
    .a_fall      (a_fall),
    .b_rise      (b_rise),
    .b_fall      (b_fall),
    .a_glitch_cnt(a_glitch_cnt),
    .b_glitch_cnt(b_glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags();
    return {a_clean, a_rise, a_fall, b_clean, b_rise, b_fall};
  endfunction

  task automatic add(input logic a, input logic b, input int unsigned t, input logic ea,
                     input logic eb, input int ar, input int af, input int br, input int bf,
                     input int ga, input int gb);
    seg_t s;
    s.a = a; s.b = b; s.ticks = t; s.ea = ea; s.eb = eb;
    s.ar = ar; s.af = af; s.br = br; s.bf = bf; s.ga = ga; s.gb = gb;
    segs.push_back(s);
  endtask

  initial begin
    seg_t s;
    int   ar, af, br, bf, viol, ia, ib;
    logic pa, pb, seen_a;

    // Segment table, starting after the glitch test: A glitch count already saturated.
    add(1'b0, 1'b0, 20, 1'b0, 1'b0, 0, 0, 0, 0, 255, 0);
    for (int i = 1; i <= 10; i++) begin
      add(logic'(i % 2), 1'b0, 3, 1'b0, 1'b0, 0, 0, 0, 0, 255, 0);
    end
    add(1'b1, 1'b0, 15, 1'b1, 1'b0, 1, 0, 0, 0, 255, 0);
    add(1'b0, 1'b0, 15, 1'b0, 1'b0, 0, 1, 0, 0, 255, 0);
    add(1'b0, 1'b1, 5,  1'b0, 1'b0, 0, 0, 0, 0, 255, 0);
    add(1'b0, 1'b0, 5,  1'b0, 1'b0, 0, 0, 0, 0, 255, 1);
    add(1'b0, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 255, 1);
    add(1'b0, 1'b0, 25, 1'b0, 1'b0, 0, 0, 1, 1, 255, 1);
    add(1'b1, 1'b1, 20, 1'b1, 1'b1, 1, 0, 1, 0, 255, 1);
    add(1'b0, 1'b0, 20, 1'b0, 1'b0, 0, 1, 0, 1, 255, 1);

    // 1. Reset state and idle.
    #12;
    check("reset flags", 32'(flags()), 32'h0);
    check("reset glitch", {a_glitch_cnt, b_glitch_cnt}, 32'h0);
    rstn = 1'b1;
    repeat (50) tick();
    check("idle flags", 32'(flags()), 32'h0);
    check("idle glitch", {a_glitch_cnt, b_glitch_cnt}, 32'h0);

    // 2. Clean rise: first sampled at tick 1, clean and strobe at tick 12.
    a_in = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 11) check("rise t11", 32'(flags()), 32'(6'b000000));
      if (i == 12) check("rise t12", 32'(flags()), 32'(6'b110000));
      if (i == 13) check("rise t13", 32'(flags()), 32'(6'b100000));
    end
    a_in = 1'b0;
    repeat (15) tick();
    check("fall back", 32'(flags()), 32'h0);
    check("no glitch yet", {a_glitch_cnt, b_glitch_cnt}, 32'h0);

    // 3. Nine-sample pulses are rejected and counted, saturating at 255.
    seen_a = 1'b0;
    for (int p = 1; p <= 300; p++) begin
      a_in = 1'b1;
      repeat (9) begin
        tick();
        seen_a |= a_clean | a_rise | a_fall;
      end
      a_in = 1'b0;
      repeat (4) begin
        tick();
        seen_a |= a_clean | a_rise | a_fall;
      end
      if (p == 1)   check("glitch 1", 32'(a_glitch_cnt), 32'd1);
      if (p == 255) check("glitch 255", 32'(a_glitch_cnt), 32'd255);
    end
    check("glitch sat", 32'(a_glitch_cnt), 32'd255);
    check("glitch no output", 32'(seen_a), 32'h0);
    check("glitch b untouched", 32'(b_glitch_cnt), 32'h0);

    // Table: bounce burst, B glitch, exact-threshold pulse, simultaneous edges.
    for (int i = 0; i < segs.size(); i++) begin
      s = segs[i];
      a_in = s.a;
      b_in = s.b;
      ar = 0; af = 0; br = 0; bf = 0; viol = 0;
      pa = a_clean;
      pb = b_clean;
      repeat (s.ticks) begin
        tick();
        ar += int'(a_rise); af += int'(a_fall);
        br += int'(b_rise); bf += int'(b_fall);
        if ((a_rise && !(a_clean && !pa)) || (a_fall && !(!a_clean && pa))) viol++;
        if ((b_rise && !(b_clean && !pb)) || (b_fall && !(!b_clean && pb))) viol++;
        pa = a_clean;
        pb = b_clean;
      end
      check($sformatf("seg%0d clean", i), {a_clean, b_clean}, {s.ea, s.eb});
      check($sformatf("seg%0d strobes", i), {8'(ar), 8'(af), 8'(br), 8'(bf)},
            {8'(s.ar), 8'(s.af), 8'(s.br), 8'(s.bf)});
      check($sformatf("seg%0d glitch", i), {a_glitch_cnt, b_glitch_cnt}, {8'(s.ga), 8'(s.gb)});
      check($sformatf("seg%0d strobe shape", i), 32'(viol), 32'h0);
    end

    // 4. Simultaneous rise and fall land on the same edge, 11 edges after first sample.
    a_in = 1'b1; b_in = 1'b1;
    ia = 0; ib = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_rise) ia = i;
      if (b_rise) ib = i;
    end
    check("simul a_rise tick", 32'(ia), 32'd12);
    check("simul b_rise tick", 32'(ib), 32'd12);
    a_in = 1'b0; b_in = 1'b0;
    ia = 0; ib = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_fall) ia = i;
      if (b_fall) ib = i;
    end
    check("simul a_fall tick", 32'(ia), 32'd12);
    check("simul b_fall tick", 32'(ib), 32'd12);

    // 6. Asynchronous reset mid-count discards everything, including a clean-high B.
    b_in = 1'b1;
    repeat (15) tick();
    check("pre-reset b_clean", 32'(flags()), 32'(6'b000100));
    a_in = 1'b1;
    repeat (6) tick();
    #2;
    rstn = 1'b0;
    #1;
    check("async reset flags", 32'(flags()), 32'h0);
    check("async reset glitch", {a_glitch_cnt, b_glitch_cnt}, 32'h0);
    @(posedge clk);
    #1;
    check("held reset flags", 32'(flags()), 32'h0);
    #2;
    rstn = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 11) check("post-reset t11", 32'(flags()), 32'(6'b000000));
      if (i == 12) check("post-reset t12", 32'(flags()), 32'(6'b110110));
      if (i == 13) check("post-reset t13", 32'(flags()), 32'(6'b100100));
    end
    check("post-reset glitch", {a_glitch_cnt, b_glitch_cnt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
